uart_core_cfg: RTL and testbench
================================

Name: uart_core_cfg

Overview:
- Next-generation UART core: baud generator, TX path and RX path, each with a parametrised FIFO, in one block.
- Adds over the current fixed UART top:
  - run-time baud divisor
  - optional even/odd parity
  - 1 or 2 stop bits
  - internal loopback, which replaces the simulation-only tx-to-rx wiring
  - sticky parity, framing and overrun error flags
- Sits between the system bus and the external tx/rx pins.

Parameters:
- DATA_WIDTH, 8, data bits per frame.
- OVERSAMPLE, 16, baud ticks per bit. Must be even and ≥ 4.
- FIFO_DEPTH, 16, entries per FIFO. Must be a power of 2 and ≥ 2.
- DIV_WIDTH, 16, width of baud_div.

Ports:
- UCLK  in  1  single system clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- baud_div  in  DIV_WIDTH  tick period minus 1, in UCLK cycles.
- parity_en  in  1  1 = parity bit present.
- parity_odd  in  1  1 = odd parity, 0 = even parity.
- two_stop  in  1  1 = two stop bits.
- loopback  in  1  1 = internal tx feeds RX; tx pin held at 1.
- W_data  in  DATA_WIDTH  TX FIFO write data.
- wr_uart  in  1  TX FIFO write strobe.
- tx_full  out  1  TX FIFO full.
- R_data  out  DATA_WIDTH  RX FIFO head (first-word fall-through).
- rd_uart  in  1  RX FIFO pop strobe.
- rx_empty  out  1  RX FIFO empty.
- rx  in  1  serial input pin (asynchronous).
- tx  out  1  serial output pin.
- err_clr  in  1  clears all error flags.
- parity_err  out  1  sticky parity error.
- frame_err  out  1  sticky framing error.
- overrun_err  out  1  sticky overrun error.

Behaviour:
- Reset (asynchronous assert, active-low):
  - FIFOs emptied, all FSMs to IDLE, tick counter cleared.
  - tx=1, tx_full=0, rx_empty=1, R_data=0, all error flags=0.
  - Reset asserted mid-frame aborts the frame immediately; tx returns to 1.
- Tick generator:
  - Counter runs 0..baud_div; tick is a 1-cycle pulse when counter==baud_div, then the counter wraps to 0.
  - Tick period is baud_div+1 cycles; baud_div=0 gives a tick every cycle.
  - Bit time is OVERSAMPLE ticks.
- FIFOs:
  - Write accepted only when not full; a write while full is ignored, even with a simultaneous read.
  - Read accepted only when not empty; a read while empty is ignored.
  - Simultaneous write and read on a non-empty, non-full FIFO: both performed, count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Flags are registered and valid the cycle after the update.
- TX FSM, states IDLE → START → DATA → PARITY → STOP:
  - Frame start: in IDLE with the TX FIFO non-empty, pop the head and latch parity_en, parity_odd and two_stop.
  - Configuration changes mid-frame take effect from the next frame.
  - Bit sequence: START drives 0; DATA drives DATA_WIDTH bits, LSB first.
  - PARITY is entered only if parity_en; bit = XOR of data, inverted if parity_odd.
  - STOP drives 1 for 1 bit, or 2 bits if two_stop. Back-to-back frames need no idle gap.
  - Each bit lasts exactly OVERSAMPLE ticks. The first START bit begins at the next tick after the pop.
- RX input path:
  - rx passes through a 2-flop synchroniser.
  - In loopback, the internal serial source is the TX shift output instead of the synchronised rx, with no synchroniser delay; tx pin = 1.
- RX FSM, states IDLE → START → DATA → PARITY → STOP:
  - IDLE: a low level seen on a tick moves to START.
  - START: after OVERSAMPLE/2 ticks, if the line is still 0 go to DATA; otherwise treat it as a glitch and return to IDLE.
  - Each later bit is sampled OVERSAMPLE ticks after the previous sample (mid-bit).
  - Only the first stop bit is checked.
- RX frame end, at the stop-bit sample:
  - Stop bit = 0: set frame_err, discard the frame, return to IDLE.
  - Parity mismatch: set parity_err and still push the data.
  - Push with the RX FIFO full: drop the data and set overrun_err.
- Error flags: sticky until err_clr; a set in the same cycle as err_clr wins.

Test Plan:
- Timing: reset, baud_div=0, OVERSAMPLE=16, loopback=1, 8N1; write 0xA5 → internal line shows 0,1,0,1,0,0,1,0,1,1 with 16 cycles per bit (160 cycles total); rx_empty falls; R_data=0xA5; tx pin stays 1 throughout.
- Parity and stop bits: loopback with parity_en=1, parity_odd=1, two_stop=1, baud_div=3; write 0x03 → parity bit 1, two stop bits, frame = 12 bits × 64 cycles; received 0x03 with parity_err=0.
- Error injection: loopback=0, drive rx externally.
  - Frame 0x55 with stop bit 0 → frame_err=1 and rx_empty stays 1.
  - Even-parity frame with a wrong parity bit → parity_err=1 and data pushed.
  - err_clr → all flags 0.
- Overrun: receive FIFO_DEPTH+1 frames (0x00..0x10) without reading → overrun_err=1; the FIFO pops 0x00..0x0F in order.
- FIFO limits and pacing: with baud_div large, write FIFO_DEPTH+2 words → tx_full=1 after FIFO_DEPTH+1 accepted (one popped immediately), extra write ignored; simultaneous rd_uart with RX FIFO empty → ignored.
- Mid-operation events:
  - Assert reset during the DATA bit 3 of a frame → tx=1 immediately, FIFOs empty; after release, a new write transmits normally.
  - A 4-tick rx low glitch → no frame received.

Source files
------------

// File: rtl/uart_core_cfg.sv
// -----------------------------------------------------------------------------
// uart_core_cfg : configurable UART core (baud tick generator, TX path, RX path,
// one FIFO per direction).
//
// Ports
//   UCLK        system clock, all logic on its rising edge
//   reset       asynchronous active-low reset
//   baud_div    tick period minus 1, in UCLK cycles
//   parity_en   parity bit present
//   parity_odd  1 = odd parity, 0 = even parity
//   two_stop    TX sends two stop bits
//   loopback    TX line feeds RX internally, tx pin held high
//   W_data      TX FIFO write data        wr_uart   TX FIFO write strobe
//   tx_full     TX FIFO full
//   R_data      RX FIFO head (first-word fall-through)
//   rd_uart     RX FIFO pop strobe        rx_empty  RX FIFO empty
//   rx          serial input pin (asynchronous)
//   tx          serial output pin
//   err_clr     clears all sticky error flags
//   parity_err / frame_err / overrun_err  sticky error flags
//
// uart_fifo is a small synchronous FIFO with registered full/empty flags and
// a first-word fall-through read port.
// -----------------------------------------------------------------------------
module uart_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_i,
    input  logic [W-1:0] wdata_i,
    input  logic         rd_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          full_q, empty_q;
    logic          do_wr, do_rd;

    // A write while full is dropped even if a read happens in the same cycle.
    assign do_wr = wr_i && !full_q;
    assign do_rd = rd_i && !empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_wr);
        rd_ptr_d = rd_ptr_q + AW'(do_rd);
        cnt_d    = cnt_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= (cnt_d == (AW+1)'(DEPTH));
            empty_q  <= (cnt_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_q] <= wdata_i;
        end
    end

    // Storage is not reset, so the head is masked to zero while empty.
    assign rdata_o = empty_q ? '0 : mem[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;
endmodule

module uart_core_cfg #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  UCLK,
    input  logic                  reset,
    input  logic [DIV_WIDTH-1:0]  baud_div,
    input  logic                  parity_en,
    input  logic                  parity_odd,
    input  logic                  two_stop,
    input  logic                  loopback,
    input  logic [DATA_WIDTH-1:0] W_data,
    input  logic                  wr_uart,
    output logic                  tx_full,
    output logic [DATA_WIDTH-1:0] R_data,
    input  logic                  rd_uart,
    output logic                  rx_empty,
    input  logic                  rx,
    output logic                  tx,
    input  logic                  err_clr,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overrun_err
);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int NW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [SW-1:0] OS_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] OS_HALF = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [NW-1:0] N_LAST  = NW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    // ---------------- baud tick ----------------
    logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
    logic                 tick;

    assign tick      = (div_cnt_q == baud_div);
    // >= also recovers if baud_div is lowered below the running count.
    assign div_cnt_d = (div_cnt_q >= baud_div) ? '0 : div_cnt_q + DIV_WIDTH'(1);

    // ---------------- TX path ----------------
    logic [DATA_WIDTH-1:0] tx_head;
    logic                  tx_empty, tx_pop, tx_load, tx_bit;
    state_t                tx_state_q, tx_state_d;
    logic [SW-1:0]         tx_s_q, tx_s_d;
    logic [NW-1:0]         tx_n_q, tx_n_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  tx_par_en_q, tx_par_en_d, tx_par_odd_q, tx_par_odd_d;
    logic                  tx_two_stop_q, tx_two_stop_d;
    logic                  tx_line_q, tx_line_d;

    uart_fifo #(.W(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(UCLK), .rst_n(reset), .wr_i(wr_uart), .wdata_i(W_data),
        .rd_i(tx_pop), .rdata_o(tx_head), .full_o(tx_full), .empty_o(tx_empty)
    );

    // The line register only changes on ticks, so a popped frame starts its
    // START bit at the next tick and every bit spans exactly OVERSAMPLE ticks.
    always_comb begin
        tx_state_d    = tx_state_q;
        tx_s_d        = tx_s_q;
        tx_n_d        = tx_n_q;
        tx_data_d     = tx_data_q;
        tx_par_en_d   = tx_par_en_q;
        tx_par_odd_d  = tx_par_odd_q;
        tx_two_stop_d = tx_two_stop_q;
        tx_line_d     = tx_line_q;
        tx_pop        = 1'b0;
        tx_load       = 1'b0;
        tx_bit        = 1'b1;
        case (tx_state_q)
            S_START:  tx_bit = 1'b0;
            S_DATA:   tx_bit = tx_data_q[tx_n_q];
            S_PARITY: tx_bit = (^tx_data_q) ^ tx_par_odd_q;
            default:  tx_bit = 1'b1;
        endcase
        if (tick) begin
            tx_line_d = tx_bit;
        end
        if (tx_state_q == S_IDLE) begin
            tx_load = !tx_empty;
        end else if (tick) begin
            if (tx_s_q != OS_LAST) begin
                tx_s_d = tx_s_q + SW'(1);
            end else begin
                tx_s_d = '0;
                case (tx_state_q)
                    S_START: begin
                        tx_state_d = S_DATA;
                        tx_n_d     = '0;
                    end
                    S_DATA: begin
                        if (tx_n_q == N_LAST) begin
                            tx_n_d     = '0;
                            tx_state_d = tx_par_en_q ? S_PARITY : S_STOP;
                        end else begin
                            tx_n_d = tx_n_q + NW'(1);
                        end
                    end
                    S_PARITY: tx_state_d = S_STOP;
                    S_STOP: begin
                        if (tx_two_stop_q && (tx_n_q == '0)) begin
                            tx_n_d = NW'(1);
                        end else begin
                            // Chain straight into the next frame: no idle gap.
                            tx_state_d = S_IDLE;
                            tx_load    = !tx_empty;
                        end
                    end
                    default: tx_state_d = S_IDLE;
                endcase
            end
        end
        if (tx_load) begin
            tx_pop        = 1'b1;
            tx_data_d     = tx_head;
            tx_par_en_d   = parity_en;
            tx_par_odd_d  = parity_odd;
            tx_two_stop_d = two_stop;
            tx_state_d    = S_START;
            tx_s_d        = '0;
            tx_n_d        = '0;
        end
    end

    assign tx = loopback ? 1'b1 : tx_line_q;

    // ---------------- RX path ----------------
    logic                  rx_meta_q, rx_sync_q, rx_in;
    logic                  rx_full, rx_push, set_par, set_frame, set_ovr;
    state_t                rx_state_q, rx_state_d;
    logic [SW-1:0]         rx_s_q, rx_s_d;
    logic [NW-1:0]         rx_n_q, rx_n_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic                  rx_par_bad_q, rx_par_bad_d;
    logic                  parity_err_q, frame_err_q, overrun_err_q;

    // Loopback taps the TX line register directly, bypassing the synchroniser.
    assign rx_in = loopback ? tx_line_q : rx_sync_q;

    uart_fifo #(.W(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(UCLK), .rst_n(reset), .wr_i(rx_push), .wdata_i(rx_shift_q),
        .rd_i(rd_uart), .rdata_o(R_data), .full_o(rx_full), .empty_o(rx_empty)
    );

    always_comb begin
        rx_state_d   = rx_state_q;
        rx_s_d       = rx_s_q;
        rx_n_d       = rx_n_q;
        rx_shift_d   = rx_shift_q;
        rx_par_bad_d = rx_par_bad_q;
        rx_push      = 1'b0;
        set_par      = 1'b0;
        set_frame    = 1'b0;
        set_ovr      = 1'b0;
        if (tick) begin
            case (rx_state_q)
                S_IDLE: begin
                    if (!rx_in) begin
                        rx_state_d = S_START;
                        rx_s_d     = '0;
                    end
                end
                S_START: begin
                    if (rx_s_q == OS_HALF) begin
                        // Still low at mid start bit: real frame, else glitch.
                        rx_s_d       = '0;
                        rx_n_d       = '0;
                        rx_par_bad_d = 1'b0;
                        rx_state_d   = rx_in ? S_IDLE : S_DATA;
                    end else begin
                        rx_s_d = rx_s_q + SW'(1);
                    end
                end
                default: begin
                    if (rx_s_q != OS_LAST) begin
                        rx_s_d = rx_s_q + SW'(1);
                    end else begin
                        rx_s_d = '0;
                        case (rx_state_q)
                            S_DATA: begin
                                rx_shift_d = {rx_in, rx_shift_q[DATA_WIDTH-1:1]};
                                if (rx_n_q == N_LAST) begin
                                    rx_state_d = parity_en ? S_PARITY : S_STOP;
                                end else begin
                                    rx_n_d = rx_n_q + NW'(1);
                                end
                            end
                            S_PARITY: begin
                                rx_par_bad_d = (rx_in != ((^rx_shift_q) ^ parity_odd));
                                rx_state_d   = S_STOP;
                            end
                            default: begin
                                rx_state_d = S_IDLE;
                                if (!rx_in) begin
                                    set_frame = 1'b1;
                                end else begin
                                    rx_push = 1'b1;
                                    set_ovr = rx_full;
                                    set_par = rx_par_bad_q;
                                end
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign parity_err  = parity_err_q;
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_err_q;

    // ---------------- state registers ----------------
    always_ff @(posedge UCLK or negedge reset) begin
        if (!reset) begin
            div_cnt_q     <= '0;
            tx_state_q    <= S_IDLE;
            tx_s_q        <= '0;
            tx_n_q        <= '0;
            tx_data_q     <= '0;
            tx_par_en_q   <= 1'b0;
            tx_par_odd_q  <= 1'b0;
            tx_two_stop_q <= 1'b0;
            tx_line_q     <= 1'b1;
            rx_meta_q     <= 1'b1;
            rx_sync_q     <= 1'b1;
            rx_state_q    <= S_IDLE;
            rx_s_q        <= '0;
            rx_n_q        <= '0;
            rx_shift_q    <= '0;
            rx_par_bad_q  <= 1'b0;
            parity_err_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            tx_state_q    <= tx_state_d;
            tx_s_q        <= tx_s_d;
            tx_n_q        <= tx_n_d;
            tx_data_q     <= tx_data_d;
            tx_par_en_q   <= tx_par_en_d;
            tx_par_odd_q  <= tx_par_odd_d;
            tx_two_stop_q <= tx_two_stop_d;
            tx_line_q     <= tx_line_d;
            rx_meta_q     <= rx;
            rx_sync_q     <= rx_meta_q;
            rx_state_q    <= rx_state_d;
            rx_s_q        <= rx_s_d;
            rx_n_q        <= rx_n_d;
            rx_shift_q    <= rx_shift_d;
            rx_par_bad_q  <= rx_par_bad_d;
            // A new error in the same cycle as err_clr takes priority.
            parity_err_q  <= set_par   | (parity_err_q  & ~err_clr);
            frame_err_q   <= set_frame | (frame_err_q   & ~err_clr);
            overrun_err_q <= set_ovr   | (overrun_err_q & ~err_clr);
        end
    end
endmodule

// File: tb/tb_uart_core_cfg.sv
// -----------------------------------------------------------------------------
// tb_uart_core_cfg : directed self-checking bench for uart_core_cfg.
// Expected received bytes go into a scoreboard queue when the stimulus is
// driven and are popped when the RX FIFO presents data.
// -----------------------------------------------------------------------------
module tb_uart_core_cfg;
    logic        UCLK = 1'b0;
    logic        reset;
    logic [15:0] baud_div;
    logic        parity_en, parity_odd, two_stop, loopback;
    logic [7:0]  W_data;
    logic        wr_uart, tx_full;
    logic [7:0]  R_data;
    logic        rd_uart, rx_empty, rx, tx, err_clr;
    logic        parity_err, frame_err, overrun_err;

    int          nerr = 0;
    int          nchk = 0;
    logic [7:0]  exp_q [$];

    always #5 UCLK = ~UCLK;

    uart_core_cfg #(.DATA_WIDTH(8), .OVERSAMPLE(16), .FIFO_DEPTH(16), .DIV_WIDTH(16)) dut (
        .UCLK(UCLK), .reset(reset), .baud_div(baud_div),
        .parity_en(parity_en), .parity_odd(parity_odd), .two_stop(two_stop),
        .loopback(loopback), .W_data(W_data), .wr_uart(wr_uart), .tx_full(tx_full),
        .R_data(R_data), .rd_uart(rd_uart), .rx_empty(rx_empty), .rx(rx), .tx(tx),
        .err_clr(err_clr), .parity_err(parity_err), .frame_err(frame_err),
        .overrun_err(overrun_err)
    );

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_tx(input logic [7:0] d);
        W_data  = d;
        wr_uart = 1'b1;
        @(negedge UCLK);
        wr_uart = 1'b0;
        $display("tx write %02h", d);
    endtask

    task automatic read_check(input string tag);
        int         n;
        logic [7:0] e;
        n = 0;
        while (rx_empty && n < 3000) begin
            @(negedge UCLK);
            n++;
        end
        check({tag, "_avail"}, {31'd0, rx_empty}, 32'd0);
        if (!rx_empty) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            check(tag, {24'd0, R_data}, {24'd0, e});
            $display("rx read %02h (expected %02h)", R_data, e);
            rd_uart = 1'b1;
            @(negedge UCLK);
            rd_uart = 1'b0;
        end
    endtask

    // Checks the first and last cycle of every bit of one frame on the
    // internal TX line, then that the tx pin never dropped.
    task automatic check_frame(input string tag, input logic [15:0] bits,
                               input int nbits, input int bitcyc);
        int   n;
        logic tx_low;
        n = 0;
        while (dut.tx_line_q !== 1'b0 && n < 200) begin
            @(negedge UCLK);
            n++;
        end
        check({tag, "_start"}, {31'd0, dut.tx_line_q}, 32'd0);
        tx_low = 1'b0;
        for (int c = 0; c < nbits * bitcyc; c++) begin
            if (tx !== 1'b1) tx_low = 1'b1;
            if ((c % bitcyc == 0) || (c % bitcyc == bitcyc - 1)) begin
                check($sformatf("%s_bit%0d_cyc%0d", tag, c / bitcyc, c % bitcyc),
                      {31'd0, dut.tx_line_q}, {31'd0, bits[c / bitcyc]});
            end
            @(negedge UCLK);
        end
        check({tag, "_idle"}, {31'd0, dut.tx_line_q}, 32'd1);
        check({tag, "_txpin_high"}, {31'd0, tx_low}, 32'd0);
        $display("frame %s checked (%0d bits x %0d cycles)", tag, nbits, bitcyc);
    endtask

    // External rx frame, 16 cycles per bit (baud_div = 0).
    task automatic send_rx(input logic [7:0] d, input logic has_par,
                           input logic par_bit, input logic stop_bit);
        rx = 1'b0;
        repeat (16) @(negedge UCLK);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (16) @(negedge UCLK);
        end
        if (has_par) begin
            rx = par_bit;
            repeat (16) @(negedge UCLK);
        end
        rx = stop_bit;
        repeat (16) @(negedge UCLK);
        rx = 1'b1;
        repeat (40) @(negedge UCLK);
        $display("rx drive %02h par=%0b/%0b stop=%0b", d, has_par, par_bit, stop_bit);
    endtask

    initial begin
        int n;
        reset = 1'b0; baud_div = 16'd0; parity_en = 1'b0; parity_odd = 1'b0;
        two_stop = 1'b0; loopback = 1'b1; W_data = 8'h00; wr_uart = 1'b0;
        rd_uart = 1'b0; rx = 1'b1; err_clr = 1'b0;
        repeat (3) @(negedge UCLK);

        // Reset state
        check("rst_tx",       {31'd0, tx},          32'd1);
        check("rst_tx_full",  {31'd0, tx_full},     32'd0);
        check("rst_rx_empty", {31'd0, rx_empty},    32'd1);
        check("rst_r_data",   {24'd0, R_data},      32'd0);
        check("rst_par_err",  {31'd0, parity_err},  32'd0);
        check("rst_frm_err",  {31'd0, frame_err},   32'd0);
        check("rst_ovr_err",  {31'd0, overrun_err}, 32'd0);
        reset = 1'b1;
        @(negedge UCLK);

        // 8N1 loopback timing, 0xA5
        write_tx(8'hA5);
        exp_q.push_back(8'hA5);
        check_frame("8n1", {6'd0, 1'b1, 8'hA5, 1'b0}, 10, 16);
        read_check("rx_a5");
        check("8n1_par_err", {31'd0, parity_err}, 32'd0);

        // Odd parity, two stop bits, baud_div = 3: 0x03 has parity bit 1
        baud_div = 16'd3; parity_en = 1'b1; parity_odd = 1'b1; two_stop = 1'b1;
        write_tx(8'h03);
        exp_q.push_back(8'h03);
        check_frame("8o2", {4'd0, 2'b11, 1'b1, 8'h03, 1'b0}, 12, 64);
        read_check("rx_03");
        check("8o2_par_err", {31'd0, parity_err}, 32'd0);

        // Error injection through the rx pin
        baud_div = 16'd0; parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
        loopback = 1'b0;
        @(negedge UCLK);
        send_rx(8'h55, 1'b0, 1'b0, 1'b0);
        check("frm_err_set",    {31'd0, frame_err},  32'd1);
        check("frm_discarded",  {31'd0, rx_empty},   32'd1);
        check("frm_no_par_err", {31'd0, parity_err}, 32'd0);
        parity_en = 1'b1;
        send_rx(8'h81, 1'b1, 1'b1, 1'b1);
        exp_q.push_back(8'h81);
        check("par_err_set",    {31'd0, parity_err}, 32'd1);
        check("frm_err_sticky", {31'd0, frame_err},  32'd1);
        read_check("par_data");
        err_clr = 1'b1;
        @(negedge UCLK);
        err_clr = 1'b0;
        check("clr_par", {31'd0, parity_err},  32'd0);
        check("clr_frm", {31'd0, frame_err},   32'd0);
        check("clr_ovr", {31'd0, overrun_err}, 32'd0);
        parity_en = 1'b0;

        // FIFO limits and overrun: 18 writes, 17 accepted, 0x10 overruns RX
        loopback = 1'b1;
        for (int i = 0; i < 18; i++) begin
            if (i == 16) check("tx_not_full_16", {31'd0, tx_full}, 32'd0);
            if (i == 17) check("tx_full_17",     {31'd0, tx_full}, 32'd1);
            W_data  = 8'(i);
            wr_uart = 1'b1;
            @(negedge UCLK);
        end
        wr_uart = 1'b0;
        check("tx_full_hold", {31'd0, tx_full}, 32'd1);
        $display("tx burst of 18 writes");
        for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
        n = 0;
        while (!overrun_err && n < 4000) begin
            @(negedge UCLK);
            n++;
        end
        check("ovr_set", {31'd0, overrun_err}, 32'd1);
        for (int i = 0; i < 16; i++) read_check($sformatf("ovr_rd%0d", i));
        repeat (300) @(negedge UCLK);
        check("ovr_drained", {31'd0, rx_empty}, 32'd1);

        // Pop while RX FIFO empty is ignored
        rd_uart = 1'b1;
        @(negedge UCLK);
        rd_uart = 1'b0;
        check("empty_rd_flag",  {31'd0, rx_empty}, 32'd1);
        check("empty_rd_rdata", {24'd0, R_data},   32'd0);
        write_tx(8'h77);
        exp_q.push_back(8'h77);
        read_check("after_empty_rd");
        check("after_empty_rd_empty", {31'd0, rx_empty}, 32'd1);

        // Reset in the middle of data bit 3 of 0x35 (bit3 = 0)
        loopback = 1'b0;
        write_tx(8'h35);
        n = 0;
        while (tx !== 1'b0 && n < 200) begin
            @(negedge UCLK);
            n++;
        end
        check("mid_start", {31'd0, tx}, 32'd0);
        repeat (72) @(negedge UCLK);
        check("mid_bit3", {31'd0, tx}, 32'd0);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_tx",       {31'd0, tx},          32'd1);
        check("mid_rst_tx_full",  {31'd0, tx_full},     32'd0);
        check("mid_rst_rx_empty", {31'd0, rx_empty},    32'd1);
        check("mid_rst_ovr",      {31'd0, overrun_err}, 32'd0);
        @(negedge UCLK);
        reset = 1'b1;
        @(negedge UCLK);
        $display("reset pulse mid-frame");
        loopback = 1'b1;
        write_tx(8'h5A);
        exp_q.push_back(8'h5A);
        read_check("post_rst");

        // 4-tick rx glitch is rejected, then a normal frame still arrives
        loopback = 1'b0;
        rx = 1'b0;
        repeat (4) @(negedge UCLK);
        rx = 1'b1;
        repeat (300) @(negedge UCLK);
        $display("rx glitch of 4 ticks");
        check("glitch_empty",   {31'd0, rx_empty},  32'd1);
        check("glitch_frm_err", {31'd0, frame_err}, 32'd0);
        send_rx(8'hC3, 1'b0, 1'b0, 1'b1);
        exp_q.push_back(8'hC3);
        read_check("after_glitch");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
